// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between the N-channel stream mux and its producers/consumer.
// The mux connects through the slave modport; the environment drives it
// through the master modport.
interface stream_mux_rr_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel, W-bit stream multiplexer with a single registered output stage.
// Arbitration is round-robin (mode=0, rotating pointer) or fixed priority
// (mode=1, channel 0 highest). The pointer is kept across mode changes so
// switching back to round-robin resumes where it left off.
module stream_mux_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    stream_mux_rr_if.slave        bus
);
    localparam int SEL_W = $clog2(CHANNELS);
    localparam logic [SEL_W:0] CH_EXT  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0]     out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]     ptr_q,       ptr_d;

    logic                 load;
    logic                 grant;
    logic                 found;
    logic [SEL_W-1:0]     start;
    logic [SEL_W-1:0]     winner;
    logic [SEL_W:0]       idx;
    logic [WIDTH-1:0]     win_data;

    // Output register is free when empty or being drained this cycle
    assign load  = !out_valid_q || bus.out_ready;
    assign start = mode ? '0 : ptr_q;

    // Scan channels from the start index with wrap-around; first valid wins
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = {1'b0, start} + (SEL_W+1)'(k);
            if (idx >= CH_EXT) begin
                idx = idx - CH_EXT;
            end
            if (!found && bus.in_valid[idx[SEL_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[SEL_W-1:0];
            end
        end
    end

    assign grant = load && found && !rst;

    // One-hot ready towards the winning channel only
    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.in_ready[i] = grant && (winner == SEL_W'(i));
        end
    end

    // Select the winner's data word without a variable part-select
    always_comb begin
        win_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (winner == SEL_W'(i)) begin
                win_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state of the output register and round-robin pointer
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = grant;
            if (grant) begin
                out_data_d = win_data;
                out_sel_d  = winner;
                if (!mode) begin
                    ptr_d = (winner == LAST_CH) ? '0 : winner + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the arbiter.
module tb_stream_mux_rr;
    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    logic mode;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int m_valid, m_data, m_sel, m_ptr;

    stream_mux_rr_if #(.WIDTH(W), .CHANNELS(N)) bus ();

    stream_mux_rr #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input int start, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (start + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, check ready, clock, update model, check outputs
    task automatic cycle(input logic r, input logic md, input logic [N-1:0] v,
                         input logic [N*W-1:0] d, input logic ordy);
        int w, ld, exp_rdy;
        rst           = r;
        mode          = md;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        ld      = (m_valid == 0) || ordy;
        w       = model_winner(md ? 0 : m_ptr, v);
        exp_rdy = (!r && ld && w >= 0) ? (1 << w) : 0;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
        end else if (ld) begin
            if (w >= 0) begin
                m_valid = 1;
                m_data  = (d >> (w * W)) & ((1 << W) - 1);
                m_sel   = w;
                if (!md) m_ptr = (w + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data",  32'(bus.out_data),  32'(m_data));
        chk("out_sel",   32'(bus.out_sel),   32'(m_sel));
    endtask

    initial begin
        m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
        rst = 1'b1; mode = 1'b0;
        bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b1;
        @(negedge clk);

        // Reset held with all channels valid
        cycle(1, 0, 4'b1111, 16'h4321, 1);
        cycle(1, 0, 4'b1111, 16'h4321, 1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_sel",   32'(bus.out_sel),   32'd0);
        rst = 1'b1; #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);

        // Round-robin, all valid: 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 4'b1111, 16'h4321, 1);
            chk("rr_sel",  32'(bus.out_sel),  32'(k % 4));
            chk("rr_data", 32'(bus.out_data), 32'(k % 4 + 1));
        end

        // Fixed priority: ch1 always beats ch3
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 4'b1010, 16'h9050, 1);
            chk("fx_sel",  32'(bus.out_sel),  32'd1);
            chk("fx_data", 32'(bus.out_data), 32'd5);
        end

        // Backpressure: load A from ch0, stall three cycles, then release
        cycle(0, 0, 4'b0001, 16'h432A, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 4'b1111, 16'h432A, 0);
            chk("bp_data", 32'(bus.out_data), 32'hA);
            chk("bp_sel",  32'(bus.out_sel),  32'd0);
            chk("bp_rdy",  32'(bus.in_ready), 32'd0);
        end
        cycle(0, 0, 4'b1111, 16'h432A, 1);
        chk("bp_release_sel", 32'(bus.out_sel), 32'd1);

        // Sparse then wrap-around
        cycle(0, 0, 4'b0100, 16'h0700, 1);
        chk("sp_sel",  32'(bus.out_sel),  32'd2);
        chk("sp_data", 32'(bus.out_data), 32'd7);
        cycle(0, 0, 4'b0000, 16'h0000, 1);
        chk("sp_empty", 32'(bus.out_valid), 32'd0);
        cycle(0, 0, 4'b1101, 16'hC0BA, 1);
        chk("wrap_sel3", 32'(bus.out_sel), 32'd3);
        cycle(0, 0, 4'b1101, 16'hC0BA, 1);
        chk("wrap_sel0", 32'(bus.out_sel), 32'd0);

        // Reset during a stall
        cycle(0, 0, 4'b1111, 16'h4321, 1);
        cycle(0, 0, 4'b1111, 16'h4321, 0);
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        cycle(1, 0, 4'b1111, 16'h4321, 0);
        chk("rst_stall_valid", 32'(bus.out_valid), 32'd0);
        cycle(0, 0, 4'b1111, 16'h4321, 1);
        chk("post_rst_sel", 32'(bus.out_sel), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 7) == 0) ? ~mode : mode,
                  N'($urandom),
                  (N*W)'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
